// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter_if : instruction/data client bus plus shared memory port |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mem_arbiter_if;
  // instruction side
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_cancel;
  logic        ic_ack;
  logic [31:0] ic_rdata;
  logic        ic_err;

  // data side
  logic        dc_req;
  logic        dc_we;
  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  logic [3:0]  dc_wstrb;
  logic        dc_ack;
  logic [31:0] dc_rdata;
  logic        dc_err;

  // shared memory port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  // arbiter view
  modport slave (
    input  ic_req, ic_addr, ic_cancel,
    input  dc_req, dc_we, dc_addr, dc_wdata, dc_wstrb,
    input  mem_ready, mem_rdata,
    output ic_ack, ic_rdata, ic_err,
    output dc_ack, dc_rdata, dc_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  // client / memory environment view
  modport master (
    output ic_req, ic_addr, ic_cancel,
    output dc_req, dc_we, dc_addr, dc_wdata, dc_wstrb,
    output mem_ready, mem_rdata,
    input  ic_ack, ic_rdata, ic_err,
    input  dc_ack, dc_rdata, dc_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter : round-robin I/D arbiter onto one memory port w/ timeout |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [9:0] c_CNT_LAST = 10'(TIMEOUT - 1);
  localparam logic [9:0] c_CNT_MAX  = 10'h3FF;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic [9:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_owner_d;
  logic        r_next_d;
  logic        r_cancel;

  logic        w_grant_d;
  logic        w_grant_i;
  logic        w_busy;
  logic        w_timeout;
  logic        w_ic_ack;
  logic        w_dc_ack;

  // On a tie the side that did not win last time gets the port.
  assign w_grant_d = bus.dc_req && (!bus.ic_req || r_next_d);
  assign w_grant_i = bus.ic_req && !w_grant_d;
  assign w_busy    = (r_state == BUSY_I) || (r_state == BUSY_D);
  assign w_timeout = (r_cnt == c_CNT_LAST) && !bus.mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ic_ack    = 1'b0;
    w_dc_ack    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = BUSY_D;
        end else if (w_grant_i) begin
          w_state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ready || w_timeout) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
        w_ic_ack    = !r_owner_d && !r_cancel;
        w_dc_ack    = r_owner_d;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_wstrb <= 4'd0;
      r_cnt       <= 10'd0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
      r_owner_d   <= 1'b0;
      r_next_d    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_mem_we    <= bus.dc_we;
            r_mem_addr  <= bus.dc_addr;
            r_mem_wdata <= bus.dc_wdata;
            r_mem_wstrb <= bus.dc_wstrb;
            r_cnt       <= 10'd0;
            r_owner_d   <= 1'b1;
            r_next_d    <= 1'b0;
          end else if (w_grant_i) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= bus.ic_addr;
            r_mem_wdata <= 32'd0;
            r_mem_wstrb <= 4'd0;
            r_cnt       <= 10'd0;
            r_owner_d   <= 1'b0;
            r_next_d    <= 1'b1;
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus.mem_ready) begin
            r_rdata <= r_mem_we ? 32'd0 : bus.mem_rdata;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b1;
          end
          if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + 10'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // A flushed fetch still finishes on the bus; only its response is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cancel <= 1'b0;
    end else if (r_state == RESP) begin
      r_cancel <= 1'b0;
    end else if (bus.ic_cancel &&
                 (((r_state == IDLE) && w_grant_i) || (r_state == BUSY_I))) begin
      r_cancel <= 1'b1;
    end
  end

  assign bus.mem_req   = w_busy;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;

  assign bus.ic_ack    = w_ic_ack;
  assign bus.ic_rdata  = w_ic_ack ? r_rdata : 32'd0;
  assign bus.ic_err    = w_ic_ack && r_err;
  assign bus.dc_ack    = w_dc_ack;
  assign bus.dc_rdata  = w_dc_ack ? r_rdata : 32'd0;
  assign bus.dc_err    = w_dc_ack && r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arbiter : directed + random transactions vs. transaction model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  bit   model_next_d;   // side that wins the next tie

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from IDLE. delay = busy cycle (0-based) on which
  // memory answers; >= TO means never. cancel_at: -1 none, 0 in grant cycle,
  // k>0 during busy cycle k-1.
  task automatic serve(input int delay, input logic [31:0] rd, input int cancel_at);
    bit          own_d;
    bit          cancelled;
    bit          timed_out;
    int          cat;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    own_d        = bus.dc_req && (!bus.ic_req || model_next_d);
    model_next_d = !own_d;
    exp_addr     = own_d ? bus.dc_addr : bus.ic_addr;
    exp_we       = own_d ? bus.dc_we : 1'b0;
    exp_wstrb    = own_d ? bus.dc_wstrb : 4'd0;
    exp_wdata    = bus.dc_wdata;
    cancelled    = 1'b0;
    timed_out    = 1'b1;
    cat          = cancel_at;
    if (own_d && cat == 0) cat = 1;
    if (cat == 0) begin
      bus.ic_cancel = 1'b1;
      cancelled     = 1'b1;
    end
    tick();
    bus.ic_cancel = 1'b0;
    for (int c = 0; c < TO; c++) begin
      chk("mem_req_busy", 32'(bus.mem_req), 32'd1);
      chk("mem_addr", bus.mem_addr, exp_addr);
      chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
      chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(exp_wstrb));
      if (own_d) chk("mem_wdata", bus.mem_wdata, exp_wdata);
      chk("ack_while_busy", 32'({bus.ic_ack, bus.dc_ack}), 32'd0);
      if (cat == c + 1) begin
        bus.ic_cancel = 1'b1;
        if (!own_d) cancelled = 1'b1;
      end
      if (c == delay) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rd;
        timed_out     = 1'b0;
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
      end
      tick();
      bus.ic_cancel = 1'b0;
      bus.mem_ready = 1'b0;
      if (!timed_out) break;
    end
    exp_rdata = (timed_out || exp_we) ? 32'd0 : rd;
    chk("mem_req_resp", 32'(bus.mem_req), 32'd0);
    if (own_d) begin
      chk("dc_ack", 32'(bus.dc_ack), 32'd1);
      chk("dc_rdata", bus.dc_rdata, exp_rdata);
      chk("dc_err", 32'(bus.dc_err), 32'(timed_out));
      chk("ic_idle_outs", 32'({bus.ic_ack, bus.ic_err}) | bus.ic_rdata, 32'd0);
      bus.dc_req = 1'b0;
    end else begin
      chk("ic_ack", 32'(bus.ic_ack), 32'(!cancelled));
      chk("ic_rdata", bus.ic_rdata, cancelled ? 32'd0 : exp_rdata);
      chk("ic_err", 32'(bus.ic_err), 32'(timed_out && !cancelled));
      chk("dc_idle_outs", 32'({bus.dc_ack, bus.dc_err}) | bus.dc_rdata, 32'd0);
      bus.ic_req = 1'b0;
    end
    tick();
    chk("mem_req_idle", 32'(bus.mem_req), 32'd0);
    chk("ack_idle", 32'({bus.ic_ack, bus.dc_ack}), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_next_d = 1'b1;
  endtask

  initial begin
    bus.ic_req    = 1'b0;
    bus.ic_addr   = 32'd0;
    bus.ic_cancel = 1'b0;
    bus.dc_req    = 1'b0;
    bus.dc_we     = 1'b0;
    bus.dc_addr   = 32'd0;
    bus.dc_wdata  = 32'd0;
    bus.dc_wstrb  = 4'd0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'd0;

    // reset state
    do_reset();
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_attr", 32'({bus.mem_we, bus.mem_wstrb}) | bus.mem_wdata, 32'd0);
    chk("rst_acks", 32'({bus.ic_ack, bus.dc_ack, bus.ic_err, bus.dc_err}), 32'd0);
    chk("rst_rdata", bus.ic_rdata | bus.dc_rdata, 32'd0);

    // both held from reset: D, I, D, I
    bus.ic_req  = 1'b1;
    bus.ic_addr = 32'h0000_1000;
    bus.dc_req  = 1'b1;
    bus.dc_addr = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
      chk("rr_owner_d", 32'(model_next_d), (k % 2 == 0) ? 32'd1 : 32'd0);
      serve(0, 32'hA000_0000 + 32'(k), -1);
      if (k < 2) begin
        if (k % 2 == 0) bus.dc_req = 1'b1;
        else            bus.ic_req = 1'b1;
      end
    end

    // data read, answer on busy cycle 3 (also the last legal cycle for TO=4)
    bus.dc_req  = 1'b1;
    bus.dc_we   = 1'b0;
    bus.dc_addr = 32'h0000_0100;
    serve(3, 32'hDEAD_BEEF, -1);

    // data write returns zero read data
    bus.dc_req   = 1'b1;
    bus.dc_we    = 1'b1;
    bus.dc_addr  = 32'h0000_0200;
    bus.dc_wdata = 32'h1234_5678;
    bus.dc_wstrb = 4'b0011;
    serve(2, 32'hCAFE_F00D, -1);
    bus.dc_we    = 1'b0;

    // instruction timeout
    bus.ic_req  = 1'b1;
    bus.ic_addr = 32'h0000_0040;
    serve(99, 32'h0BAD_0BAD, -1);

    // cancel during BUSY_I, then a normal data read
    bus.ic_req  = 1'b1;
    bus.ic_addr = 32'h0000_0044;
    serve(2, 32'h1111_1111, 2);
    bus.dc_req  = 1'b1;
    bus.dc_addr = 32'h0000_0108;
    serve(0, 32'h55AA_33CC, -1);

    // cancel in the grant cycle
    bus.ic_req  = 1'b1;
    bus.ic_addr = 32'h0000_0048;
    serve(1, 32'h2222_2222, 0);

    // reset mid data transaction, late mem_ready ignored
    bus.dc_req  = 1'b1;
    bus.dc_addr = 32'h0000_0300;
    tick();
    chk("pre_rst_busy", 32'(bus.mem_req), 32'd1);
    tick();
    rst        = 1'b1;
    bus.dc_req = 1'b0;
    tick();
    rst = 1'b0;
    model_next_d = 1'b1;
    chk("midrst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("midrst_dc_ack", 32'(bus.dc_ack), 32'd0);
    chk("midrst_mem_addr", bus.mem_addr, 32'd0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h7777_7777;
    tick();
    bus.mem_ready = 1'b0;
    chk("late_ready_req", 32'(bus.mem_req), 32'd0);
    chk("late_ready_ack", 32'({bus.ic_ack, bus.dc_ack}), 32'd0);
    bus.dc_req  = 1'b1;
    bus.dc_addr = 32'h0000_0304;
    bus.ic_req  = 1'b1;
    bus.ic_addr = 32'h0000_0400;
    serve(1, 32'h3333_4444, -1);
    serve(0, 32'h5555_6666, -1);

    // random traffic
    for (int n = 0; n < 80; n++) begin
      if (!bus.ic_req && $urandom_range(0, 1) == 1) begin
        bus.ic_req  = 1'b1;
        bus.ic_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!bus.dc_req && (!bus.ic_req || $urandom_range(0, 1) == 1)) begin
        bus.dc_req   = 1'b1;
        bus.dc_we    = 1'($urandom_range(0, 1));
        bus.dc_addr  = $urandom;
        bus.dc_wdata = $urandom;
        bus.dc_wstrb = 4'($urandom_range(0, 15));
      end
      serve($urandom_range(0, TO + 1), $urandom,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
    end
    if (bus.ic_req || bus.dc_req) serve(0, 32'h9999_0000, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
